// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// A frame is a start bit (0), DATA_W data bits sent LSB first, an optional
// even-parity bit and a stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
// Words are accepted by a valid/ready handshake only while the line is idle.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 1,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Counter widths never drop below one bit, even for degenerate parameters.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q,   par_d;
    logic              tx_q,    tx_d;
    logic              done_q,  done_d;
    logic              bit_end_s;

    assign bit_end_s = (cnt_q == CNT_LAST);

    // Next-state logic: frame sequencing, bit timing and data shifting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_START;
                    shift_d = in_data;
                    par_d   = even_parity(in_data);
                    cnt_d   = {CW{1'b0}};
                    idx_d   = {IW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = {CW{1'b0}};
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = {IW{1'b0}};
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
                idx_d   = {IW{1'b0}};
            end
        endcase
    end

    // Line level and end-of-frame pulse are derived from the next state so
    // that they are registered alongside it.
    always_comb begin
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            idx_q   <= {IW{1'b0}};
            shift_q <= {DATA_W{1'b0}};
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx       = tx_q;
    assign done     = done_q;

endmodule
